// File: rtl/vending_customer_pkg.sv
// Shared types for the vending customer agent: coin encoding, coin values,
// default price and the customer FSM states.
package vending_customer_pkg;

    localparam int PRICE_DFLT = 5;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        NICKEL  = 2'd1,
        DIME    = 2'd2,
        QUARTER = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAY    = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } cust_state_t;

    // Value of a coin in nickel-equivalents.
    function automatic logic [2:0] coin_value(input coin_t c);
        case (c)
            NICKEL:  coin_value = 3'd1;
            DIME:    coin_value = 3'd2;
            QUARTER: coin_value = 3'd5;
            default: coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vending_customer_wallet.sv
// Customer wallet: one saturating counter per coin type plus the coin
// selection for the next deposit.
module customer_wallet
    import vending_customer_pkg::*;
#(
    parameter int WBITS    = 4,
    parameter int N5_INIT  = 4,
    parameter int N10_INIT = 3,
    parameter int N25_INIT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             strategy,
    input  coin_t            inc,
    input  coin_t            dec,
    output logic [WBITS-1:0] n5,
    output logic [WBITS-1:0] n10,
    output logic [WBITS-1:0] n25,
    output coin_t            coin_pick
);

    // index 0 = nickel, 1 = dime, 2 = quarter (coin code minus one)
    localparam logic [2:0][WBITS-1:0] INIT = {WBITS'(N25_INIT), WBITS'(N10_INIT), WBITS'(N5_INIT)};
    localparam logic [WBITS-1:0]      CMAX = '1;

    logic [2:0][WBITS-1:0] cnt;

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_cnt
            localparam logic [1:0] CODE = 2'(i + 1);
            logic [WBITS-1:0] q;
            logic             up, dn;

            assign up = (inc == coin_t'(CODE));
            assign dn = (dec == coin_t'(CODE)) && (q != '0);

            // Counter holds when inc and dec of the same type coincide.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    q <= INIT[i];
                else if (up && !dn && q != CMAX)
                    q <= q + 1'b1;
                else if (dn && !up)
                    q <= q - 1'b1;
            end

            assign cnt[i] = q;
        end
    endgenerate

    assign n5  = cnt[0];
    assign n10 = cnt[1];
    assign n25 = cnt[2];

    // Pick the next coin, skipping empty types.
    always_comb begin
        coin_pick = NONE;
        if (!strategy) begin
            if      (cnt[2] != '0) coin_pick = QUARTER;
            else if (cnt[1] != '0) coin_pick = DIME;
            else if (cnt[0] != '0) coin_pick = NICKEL;
        end else begin
            if      (cnt[0] != '0) coin_pick = NICKEL;
            else if (cnt[1] != '0) coin_pick = DIME;
            else if (cnt[2] != '0) coin_pick = QUARTER;
        end
    end

endmodule

// File: rtl/vending_customer.sv
// Customer-side agent for the vending coin interface: pays for one item,
// collects change and classifies the outcome of each transaction.
module vending_customer
    import vending_customer_pkg::*;
#(
    parameter int WBITS    = 4,
    parameter int N5_INIT  = 4,
    parameter int N10_INIT = 3,
    parameter int N25_INIT = 2,
    parameter int PRICE    = PRICE_DFLT,
    parameter int TIMEOUT  = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              buy,
    input  logic              strategy,
    input  logic              enable,
    input  coin_t             change,
    input  logic              beverage,
    output coin_t             deposit,
    output logic              busy,
    output logic              done,
    output logic              got_item,
    output logic              refunded,
    output logic              error,
    output logic [WBITS-1:0]  n5,
    output logic [WBITS-1:0]  n10,
    output logic [WBITS-1:0]  n25,
    output logic signed [4:0] spent
);

    localparam int         TW      = $clog2(TIMEOUT + 1);
    localparam logic [3:0] PRICE_W = 4'(PRICE);

    cust_state_t       state, state_n;
    coin_t             deposit_n, pick, w_inc, w_dec;
    logic [3:0]        paid, paid_n, paid_adj;
    logic signed [4:0] spent_n;
    logic              got_item_n, refunded_n, error_n;
    logic              seen_low, seen_low_n;
    logic [TW-1:0]     wcnt, wcnt_n;
    logic [2:0]        chg_v, pick_v;

    customer_wallet #(
        .WBITS    (WBITS),
        .N5_INIT  (N5_INIT),
        .N10_INIT (N10_INIT),
        .N25_INIT (N25_INIT)
    ) u_wallet (
        .clock     (clock),
        .reset_n   (reset_n),
        .strategy  (strategy),
        .inc       (w_inc),
        .dec       (w_dec),
        .n5        (n5),
        .n10       (n10),
        .n25       (n25),
        .coin_pick (pick)
    );

    assign chg_v    = coin_value(change);
    assign pick_v   = coin_value(pick);
    // A coin rejected this cycle no longer counts as paid.
    assign paid_adj = paid - {1'b0, chg_v};

    // State and transaction registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            deposit  <= NONE;
            paid     <= '0;
            spent    <= '0;
            got_item <= 1'b0;
            refunded <= 1'b0;
            error    <= 1'b0;
            seen_low <= 1'b0;
            wcnt     <= '0;
        end else begin
            state    <= state_n;
            deposit  <= deposit_n;
            paid     <= paid_n;
            spent    <= spent_n;
            got_item <= got_item_n;
            refunded <= refunded_n;
            error    <= error_n;
            seen_low <= seen_low_n;
            wcnt     <= wcnt_n;
        end
    end

    // Next-state, deposit choice and wallet updates.
    always_comb begin
        state_n    = state;
        deposit_n  = NONE;
        paid_n     = paid;
        spent_n    = spent;
        got_item_n = got_item;
        refunded_n = refunded;
        error_n    = error;
        seen_low_n = seen_low;
        wcnt_n     = wcnt;
        w_inc      = NONE;
        w_dec      = NONE;

        // Any coin coming back during a transaction lands in the wallet.
        if (state != IDLE)
            w_inc = change;

        case (state)
            IDLE: begin
                if (buy) begin
                    paid_n     = '0;
                    spent_n    = '0;
                    got_item_n = 1'b0;
                    refunded_n = 1'b0;
                    error_n    = 1'b0;
                    state_n    = PAY;
                end
            end
            PAY: begin
                paid_n  = paid_adj;
                spent_n = spent - {2'b00, chg_v};
                if (paid_adj >= PRICE_W) begin
                    seen_low_n = 1'b0;
                    wcnt_n     = '0;
                    state_n    = WAIT;
                end else if (pick == NONE && change == NONE) begin
                    error_n = 1'b1;
                    state_n = FINISH;
                end else if (enable && pick != NONE) begin
                    deposit_n = pick;
                    w_dec     = pick;
                    paid_n    = paid_adj + {1'b0, pick_v};
                    spent_n   = spent - {2'b00, chg_v} + {2'b00, pick_v};
                end
            end
            WAIT: begin
                spent_n = spent - {2'b00, chg_v};
                if (!enable)
                    seen_low_n = 1'b1;
                if (beverage) begin
                    got_item_n = 1'b1;
                    state_n    = FINISH;
                end else if (seen_low && enable) begin
                    refunded_n = 1'b1;
                    state_n    = FINISH;
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    error_n = 1'b1;
                    state_n = FINISH;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            FINISH: begin
                spent_n = spent - {2'b00, chg_v};
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_vending_customer.sv
// Directed bench for vending_customer: three wallet configurations share the
// stimulus, each scenario looks at the instance it was written for.
module tb_vending_customer;
    import vending_customer_pkg::*;

    logic  clock = 1'b0;
    logic  reset_n, buy, strategy, enable, beverage;
    coin_t change;

    coin_t             dep [3];
    logic              bsy [3], dn [3], gi [3], rf [3], er [3];
    logic [3:0]        w5 [3], w10 [3], w25 [3];
    logic signed [4:0] sp [3];

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    vending_customer u_dut0 (
        .clock(clock), .reset_n(reset_n), .buy(buy), .strategy(strategy),
        .enable(enable), .change(change), .beverage(beverage),
        .deposit(dep[0]), .busy(bsy[0]), .done(dn[0]), .got_item(gi[0]),
        .refunded(rf[0]), .error(er[0]), .n5(w5[0]), .n10(w10[0]),
        .n25(w25[0]), .spent(sp[0]));

    vending_customer #(.N5_INIT(0), .N10_INIT(3), .N25_INIT(0)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .buy(buy), .strategy(strategy),
        .enable(enable), .change(change), .beverage(beverage),
        .deposit(dep[1]), .busy(bsy[1]), .done(dn[1]), .got_item(gi[1]),
        .refunded(rf[1]), .error(er[1]), .n5(w5[1]), .n10(w10[1]),
        .n25(w25[1]), .spent(sp[1]));

    vending_customer #(.N5_INIT(1), .N10_INIT(1), .N25_INIT(0)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .buy(buy), .strategy(strategy),
        .enable(enable), .change(change), .beverage(beverage),
        .deposit(dep[2]), .busy(bsy[2]), .done(dn[2]), .got_item(gi[2]),
        .refunded(rf[2]), .error(er[2]), .n5(w5[2]), .n10(w10[2]),
        .n25(w25[2]), .spent(sp[2]));

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_wallet(input string tag, input int k, input int e5, input int e10, input int e25);
        chk({tag, "_n5"},  int'(w5[k]),  e5);
        chk({tag, "_n10"}, int'(w10[k]), e10);
        chk({tag, "_n25"}, int'(w25[k]), e25);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n  = 1'b0;
        buy      = 1'b0;
        strategy = 1'b0;
        enable   = 1'b0;
        change   = NONE;
        beverage = 1'b0;
        step;
        step;
        reset_n  = 1'b1;
    endtask

    task automatic start_buy(input logic strat);
        strategy = strat;
        enable   = 1'b1;
        buy      = 1'b1;
        step;
        buy      = 1'b0;
    endtask

    initial begin
        int seq [5];
        logic early;
        seq = '{1, 1, 1, 1, 2};

        // reset state
        do_reset;
        chk("rst_dep", int'(dep[0]), int'(NONE));
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_done", int'(dn[0]), 0);
        chk("rst_flags", int'({gi[0], rf[0], er[0]}), 0);
        chk("rst_spent", int'(sp[0]), 0);
        chk_wallet("rst0", 0, 4, 3, 2);
        chk_wallet("rst1", 1, 0, 3, 0);

        // largest first: one quarter pays, item arrives
        start_buy(1'b0);
        chk("t1_busy", int'(bsy[0]), 1);
        chk("t1_dep_pay0", int'(dep[0]), int'(NONE));
        step;
        chk("t1_dep_q", int'(dep[0]), int'(QUARTER));
        chk("t1_n25", int'(w25[0]), 1);
        chk("t1_spent_pay", int'(sp[0]), 5);
        enable = 1'b0;
        step;
        chk("t1_dep_none", int'(dep[0]), int'(NONE));
        chk("t1_done_early", int'(dn[0]), 0);
        beverage = 1'b1;
        step;
        beverage = 1'b0;
        chk("t1_done", int'(dn[0]), 1);
        chk("t1_got", int'(gi[0]), 1);
        chk("t1_ref_err", int'({rf[0], er[0]}), 0);
        chk("t1_spent", int'(sp[0]), 5);
        chk_wallet("t1", 0, 4, 3, 1);
        step;
        chk("t1_done_pulse", int'(dn[0]), 0);
        chk("t1_idle", int'(bsy[0]), 0);
        chk("t1_got_sticky", int'(gi[0]), 1);

        // smallest first: N,N,N,N,D then one nickel of change
        do_reset;
        start_buy(1'b1);
        for (int k = 0; k < 5; k++) begin
            step;
            chk($sformatf("t2_dep%0d", k), int'(dep[0]), seq[k]);
        end
        chk("t2_spent_pay", int'(sp[0]), 6);
        chk_wallet("t2_pay", 0, 0, 2, 2);
        step;
        chk("t2_dep_none", int'(dep[0]), int'(NONE));
        enable   = 1'b0;
        change   = NICKEL;
        beverage = 1'b1;
        step;
        change   = NONE;
        beverage = 1'b0;
        chk("t2_got", int'(gi[0]), 1);
        chk("t2_done", int'(dn[0]), 1);
        chk("t2_spent", int'(sp[0]), 5);
        chk_wallet("t2", 0, 1, 2, 2);
        step;

        // dimes only, machine refunds all three
        do_reset;
        start_buy(1'b0);
        for (int k = 0; k < 3; k++) begin
            step;
            chk($sformatf("t3_dep%0d", k), int'(dep[1]), int'(DIME));
        end
        step;
        chk("t3_dep_none", int'(dep[1]), int'(NONE));
        chk("t3_spent_pay", int'(sp[1]), 6);
        chk("t3_n10_pay", int'(w10[1]), 0);
        enable = 1'b0;
        change = DIME;
        repeat (3) step;
        change = NONE;
        chk("t3_n10_back", int'(w10[1]), 3);
        chk("t3_wait_busy", int'(bsy[1]), 1);
        chk("t3_wait_done", int'(dn[1]), 0);
        enable = 1'b1;
        step;
        chk("t3_refunded", int'(rf[1]), 1);
        chk("t3_done", int'(dn[1]), 1);
        chk("t3_got_err", int'({gi[1], er[1]}), 0);
        chk("t3_spent", int'(sp[1]), 0);
        step;

        // wallet runs dry at paid=3
        do_reset;
        start_buy(1'b1);
        step;
        chk("t4_dep_n", int'(dep[2]), int'(NICKEL));
        step;
        chk("t4_dep_d", int'(dep[2]), int'(DIME));
        chk("t4_spent", int'(sp[2]), 3);
        step;
        chk("t4_error", int'(er[2]), 1);
        chk("t4_done", int'(dn[2]), 1);
        chk("t4_dep_none", int'(dep[2]), int'(NONE));
        chk_wallet("t4", 2, 0, 0, 0);
        step;
        chk("t4_done_pulse", int'(dn[2]), 0);
        chk("t4_dep_idle", int'(dep[2]), int'(NONE));
        chk("t4_err_sticky", int'(er[2]), 1);

        // machine never answers: timeout after 15 WAIT cycles, stray buy ignored
        do_reset;
        start_buy(1'b0);
        step;
        enable = 1'b0;
        step;
        early = 1'b0;
        for (int k = 0; k < 14; k++) begin
            buy = (k == 5);
            step;
            early = early | dn[0] | !bsy[0];
        end
        buy = 1'b0;
        chk("t5_early", int'(early), 0);
        step;
        chk("t5_done", int'(dn[0]), 1);
        chk("t5_error", int'(er[0]), 1);
        chk("t5_got_ref", int'({gi[0], rf[0]}), 0);
        step;
        chk("t5_idle", int'(bsy[0]), 0);

        // reset in the middle of PAY while a dime is on offer
        do_reset;
        start_buy(1'b1);
        repeat (5) step;
        chk("t6_dep_d", int'(dep[0]), int'(DIME));
        #1 reset_n = 1'b0;
        #1;
        chk("t6_dep", int'(dep[0]), int'(NONE));
        chk("t6_busy", int'(bsy[0]), 0);
        chk("t6_spent", int'(sp[0]), 0);
        chk_wallet("t6", 0, 4, 3, 2);
        reset_n = 1'b1;
        step;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vending_customer.md
Name: vending_customer

Overview:
- Customer-side agent for the vending coin interface. Drives `deposit`, obeys `enable`, and collects `change` into its own wallet.
- Detects the transaction outcome: item dispensed, refund, insufficient funds, or timeout.
- Sits opposite the vending machine in the environment. It replaces the nondeterministic coin source for directed and self-checking runs.
- Keeps its own wallet and net-spend count so a bench can check conservation of money.

Parameters:
- WBITS, 4, width of each wallet coin counter; counters saturate at 2^WBITS-1.
- N5_INIT, 4, nickels in the wallet at reset.
- N10_INIT, 3, dimes in the wallet at reset.
- N25_INIT, 2, quarters in the wallet at reset.
- PRICE, 5, item price in nickel-equivalents.
- TIMEOUT, 15, maximum cycles in WAIT before the agent gives up.

Ports:
- clock  in  1  the single clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- buy  in  1  one-cycle pulse that starts a purchase; ignored unless in IDLE.
- strategy  in  1  0 = largest coin first (Q, D, N); 1 = smallest coin first (N, D, Q).
- enable  in  1  machine accepts coins.
- change  in  Coin  coin returned by the machine this cycle.
- beverage  in  1  item released this cycle.
- deposit  out  Coin  registered coin offered to the machine.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at the end of a transaction.
- got_item  out  1  sticky until the next buy; item received.
- refunded  out  1  sticky; machine ended the transaction without an item.
- error  out  1  sticky; wallet ran out or timeout.
- n5, n10, n25  out  WBITS each  wallet counts.
- spent  out  5  signed net nickel-equivalents given away this transaction.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE; deposit = NONE.
  - n5/n10/n25 = *_INIT.
  - paid = 0; spent = 0.
  - all flags and done = 0.
- Coin values: NICKEL=1, DIME=2, QUARTER=5, NONE=0. Arithmetic is in nickel-equivalents.
- `paid` is a 4-bit register counting nickel-equivalents in flight or accepted.
- States: IDLE, PAY, WAIT, FINISH.
- IDLE:
  - deposit = NONE.
  - On buy: clear paid, spent, got_item, refunded, error; go to PAY.
- PAY, at each posedge:
  - If enable == 1, paid < PRICE and a coin is available: deposit = the chosen coin per strategy, its wallet count -1, paid += value, spent += value.
  - Otherwise deposit = NONE.
  - Largest-first skips coin types with count 0. A coin is never offered when enable == 0.
  - When paid >= PRICE, deposit = NONE and go to WAIT.
  - If paid < PRICE and the wallet is empty: error = 1, go to FINISH.
- Change in PAY: a non-NONE change is a rejected coin. Wallet count +1, paid -= value, spent -= value.
- Change in WAIT: wallet count +1, spent -= value. Change is absorbed in the same cycle as beverage if both occur.
- WAIT has a seen_low flag, set once enable == 0 is sampled. It absorbs the 1–2 cycle lag of deposit/enable.
- WAIT exits:
  - beverage == 1: got_item = 1, go to FINISH.
  - seen_low and enable == 1 and no beverage seen: refunded = 1, go to FINISH.
  - A cycle counter reaching TIMEOUT: error = 1, go to FINISH.
- FINISH: done = 1 for exactly one cycle, then IDLE. Change still arriving in FINISH is absorbed into the wallet.
- Wallet counters saturate at max and never go below 0. A count of 0 is never selected.
- buy asserted while busy is ignored.
- Reset mid-transaction discards the transaction completely.

Decomposition:
- Shared package holds:
  - the Coin enum (NONE, NICKEL, DIME, QUARTER);
  - the coin_value function;
  - the PRICE default;
  - the customer state enum.
- One sub-module, customer_wallet:
  - three saturating counters with inc/dec per coin type;
  - a coin_pick output, combinational from the counts and strategy.

Test Plan:
- Defaults, strategy=0, buy -> deposit QUARTER for exactly one cycle then NONE; beverage arrives -> done, got_item=1, n25=1, spent=5.
- strategy=1, defaults, machine holds t5>0 -> N,N,N,N,D offered, paid=6; one NICKEL returned -> got_item=1, n5=1, n10=2, spent=5.
- N5_INIT=0, N25_INIT=0, N10_INIT=3, machine t5=0 -> D,D,D offered; machine refunds 3 DIMEs, enable returns -> refunded=1, n10=3, spent=0.
- N5_INIT=1, N10_INIT=1, N25_INIT=0 -> N, D offered, paid=3, wallet empty -> error=1, done pulse, deposit stays NONE.
- Machine holds enable=0 and never asserts beverage after payment -> error=1 and done after exactly 15 WAIT cycles.
- reset_n pulled low mid-PAY with deposit=DIME -> deposit=NONE before the next edge, wallet back to 4/3/2, busy=0.
